// File: rtl/trackball_quad_encoder.sv
// Trackball emulator: converts signed host motion deltas into paced
// two-phase (Gray-coded) quadrature outputs per axis for the game core.
// Optional joystick-driven stepping is compiled in when TRACKBALL_JOY_EN
// is defined; without it the joy_* ports and their logic do not exist.
module trackball_quad_encoder #(
  parameter int STEP_DIV = 1024,
  parameter int ACC_W    = 12
`ifdef TRACKBALL_JOY_EN
  , parameter int JOY_DIV = 4
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mv_strobe,
  input  logic [8:0] dx,
  input  logic [8:0] dy,
  input  logic       flip,
`ifdef TRACKBALL_JOY_EN
  input  logic       joy_up,
  input  logic       joy_down,
  input  logic       joy_left,
  input  logic       joy_right,
`endif
  output logic       xa,
  output logic       xb,
  output logic       ya,
  output logic       yb,
  output logic       busy
);

  localparam int SW = ACC_W + 1;
  localparam logic [15:0] PRESC_LAST = 16'(STEP_DIV - 1);
  localparam logic signed [SW-1:0] ACC_MAX = SW'((1 <<< (ACC_W - 1)) - 1);
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;

  // Clamp to the symmetric range so the most-negative code never appears.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SW-1:0] v);
    if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                  return v[ACC_W-1:0];
  endfunction

  // Sign-extend a 9-bit delta to SW bits before negating so -(-256) fits.
  function automatic logic signed [SW-1:0] ext_delta(input logic [8:0] d, input logic neg);
    logic signed [SW-1:0] e;
    e = SW'($signed(d));
    return neg ? -e : e;
  endfunction

  function automatic logic signed [1:0] step_of(input logic signed [ACC_W-1:0] a);
    if (a > 0)      return 2'sd1;
    else if (a < 0) return -2'sd1;
    else            return 2'sd0;
  endfunction

  function automatic logic [1:0] gray(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  logic [15:0]              r_presc;
  logic                     w_tick;
  logic signed [ACC_W-1:0]  r_acc_x, r_acc_y, w_acc_x_nxt, w_acc_y_nxt;
  logic signed [SW-1:0]     w_dx_add, w_dy_add;
  logic signed [1:0]        w_x_step, w_y_step, w_x_acc_step, w_y_acc_step;
  logic [1:0]               r_xph, r_yph, w_xph_nxt, w_yph_nxt;
  logic [1:0]               r_xab, r_yab;
  logic                     r_busy;

  assign w_tick = (r_presc == PRESC_LAST);

`ifdef TRACKBALL_JOY_EN
  logic [15:0]       r_joyc;
  logic              w_jtick, w_x_joy, w_y_joy;
  logic signed [1:0] w_x_jdir, w_y_jdir;

  assign w_jtick  = w_tick && (r_joyc == 16'(JOY_DIV - 1));
  assign w_x_joy  = w_jtick && (joy_left ^ joy_right);
  assign w_y_joy  = w_jtick && (joy_up ^ joy_down);
  assign w_x_jdir = (joy_right ^ flip) ? 2'sd1 : -2'sd1;
  assign w_y_jdir = (joy_down ^ flip) ? 2'sd1 : -2'sd1;

  // Count ticks so joystick steps fire once every JOY_DIV step opportunities.
  always_ff @(posedge clk) begin
    if (!reset_n)    r_joyc <= '0;
    else if (w_tick) r_joyc <= (r_joyc == 16'(JOY_DIV - 1)) ? '0 : r_joyc + 16'd1;
  end
`endif

  // Step choice from pre-update accumulators, then saturated accumulator update.
  always_comb begin
    w_dx_add     = mv_strobe ? ext_delta(dx, flip) : SW'(0);
    w_dy_add     = mv_strobe ? ext_delta(dy, flip) : SW'(0);
    w_x_acc_step = w_tick ? step_of(r_acc_x) : 2'sd0;
    w_y_acc_step = w_tick ? step_of(r_acc_y) : 2'sd0;
    w_x_step     = w_x_acc_step;
    w_y_step     = w_y_acc_step;
`ifdef TRACKBALL_JOY_EN
    // A joystick step takes the tick; pending mouse motion waits untouched.
    if (w_x_joy) begin
      w_x_step     = w_x_jdir;
      w_x_acc_step = 2'sd0;
    end
    if (w_y_joy) begin
      w_y_step     = w_y_jdir;
      w_y_acc_step = 2'sd0;
    end
`endif
    w_acc_x_nxt = sat_acc(SW'(r_acc_x) + w_dx_add - SW'(w_x_acc_step));
    w_acc_y_nxt = sat_acc(SW'(r_acc_y) + w_dy_add - SW'(w_y_acc_step));
    w_xph_nxt   = r_xph + $unsigned(w_x_step);
    w_yph_nxt   = r_yph + $unsigned(w_y_step);
  end

  // Prescaler, accumulators, phase counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_acc_x <= '0;
      r_acc_y <= '0;
      r_xph   <= '0;
      r_yph   <= '0;
      r_xab   <= '0;
      r_yab   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 16'd1;
      r_acc_x <= w_acc_x_nxt;
      r_acc_y <= w_acc_y_nxt;
      r_xph   <= w_xph_nxt;
      r_yph   <= w_yph_nxt;
      r_xab   <= gray(w_xph_nxt);
      r_yab   <= gray(w_yph_nxt);
      r_busy  <= (w_acc_x_nxt != '0) || (w_acc_y_nxt != '0);
    end
  end

  assign {xa, xb} = r_xab;
  assign {ya, yb} = r_yab;
  assign busy     = r_busy;

endmodule

// File: tb/tb_trackball_quad_encoder.sv
// Scoreboard bench for trackball_quad_encoder (STEP_DIV=8, ACC_W=10).
// Expected {xa,xb,ya,yb,busy} snapshots are queued by the stimulus; a
// monitor pops one each time the quadrature outputs change.
module tb_trackball_quad_encoder;
  localparam int STEP_DIV = 8;
  localparam int ACC_W    = 10;
`ifdef TRACKBALL_JOY_EN
  localparam int JOY_DIV  = 4;
`endif

  logic       clk = 1'b0;
  logic       reset_n, mv_strobe, flip;
  logic [8:0] dx, dy;
  logic       xa, xb, ya, yb, busy;
`ifdef TRACKBALL_JOY_EN
  logic       joy_up, joy_down, joy_left, joy_right;
`endif

  always #5 clk = ~clk;

  trackball_quad_encoder #(
    .STEP_DIV(STEP_DIV),
    .ACC_W(ACC_W)
`ifdef TRACKBALL_JOY_EN
    , .JOY_DIV(JOY_DIV)
`endif
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mv_strobe(mv_strobe),
    .dx(dx),
    .dy(dy),
    .flip(flip),
`ifdef TRACKBALL_JOY_EN
    .joy_up(joy_up),
    .joy_down(joy_down),
    .joy_left(joy_left),
    .joy_right(joy_right),
`endif
    .xa(xa),
    .xb(xb),
    .ya(ya),
    .yb(yb),
    .busy(busy)
  );

  int         checks = 0;
  int         fails  = 0;
  logic [4:0] exp_q[$];
  int         tb_presc = 0;
  bit         tb_rst_edge = 1'b1;
  logic [3:0] prev_out = 4'b0000;

  // Reference prescaler phase: 0 right after reset, wraps at STEP_DIV-1.
  always @(posedge clk) begin
    tb_rst_edge <= !reset_n;
    if (!reset_n) tb_presc <= 0;
    else          tb_presc <= (tb_presc == STEP_DIV - 1) ? 0 : tb_presc + 1;
  end

  // Monitor: every output change must match the next queued snapshot and
  // must land on the edge right after a tick (prescaler back at 0).
  always @(negedge clk) begin
    logic [3:0] cur;
    logic [4:0] e;
    cur = {xa, xb, ya, yb};
    if (!tb_rst_edge && cur != prev_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_step: outputs=%b busy=%b, required no change from %b", cur, busy, prev_out);
      end else begin
        e = exp_q.pop_front();
        if ({cur, busy} !== e) begin
          fails++;
          $display("FAIL step_value: {xa,xb,ya,yb,busy}=%b, required %b", {cur, busy}, e);
        end
      end
      checks++;
      if (tb_presc != 0) begin
        fails++;
        $display("FAIL step_timing: change with prescaler phase %0d, required 0 (cycle after tick)", tb_presc);
      end
    end
    prev_out = cur;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [1:0] tb_gray(input int s);
    case (s % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic push(input logic [3:0] o, input logic b);
    exp_q.push_back({o, b});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'd0, xa, xb, ya, yb}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic wait_presc(input int v);
    for (int i = 0; i < 2 * STEP_DIV; i++) begin
      @(negedge clk);
      if (tb_presc == v) return;
    end
    checks++;
    fails++;
    $display("FAIL presc_align: phase %0d not seen, required %0d", tb_presc, v);
  endtask

  task automatic strobe(input int dxv, input int dyv, input logic fl);
    mv_strobe = 1'b1;
    dx = 9'(dxv);
    dy = 9'(dyv);
    flip = fl;
    @(negedge clk);
    mv_strobe = 1'b0;
    dx = '0;
    dy = '0;
    flip = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) return;
      @(negedge clk);
    end
    checks++;
    fails++;
    $display("FAIL step_timeout: %0d steps still pending, required 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic drain(input int bound);
    wait_empty(bound);
    repeat (3 * STEP_DIV) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    mv_strobe = 1'b0;
    dx = '0;
    dy = '0;
    flip = 1'b0;
`ifdef TRACKBALL_JOY_EN
    joy_up = 1'b0;
    joy_down = 1'b0;
    joy_left = 1'b0;
    joy_right = 1'b0;
`endif

    // Reset mid-motion: two steps out of dx=+52, then reset with acc_x=50.
    do_reset();
    push(4'b0100, 1'b1);
    push(4'b1100, 1'b1);
    wait_presc(1);
    strobe(52, 0, 1'b0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    wait_empty(4 * STEP_DIV);
    do_reset();
    repeat (10 * STEP_DIV) @(negedge clk);
    check("post_reset_busy", {31'd0, busy}, 32'd0);
    check("post_reset_queue", exp_q.size(), 0);

    // dx=+3: X walks 00->01->11->10, busy drops with the last step.
    do_reset();
    push(4'b0100, 1'b1);
    push(4'b1100, 1'b1);
    push(4'b1000, 1'b0);
    wait_presc(1);
    strobe(3, 0, 1'b0);
    check("busy_plus3", {31'd0, busy}, 32'd1);
    drain(6 * STEP_DIV);

    // dx=-2 unflipped (0->3->2), then dx=-2 flipped (2->3->0).
    do_reset();
    push(4'b1000, 1'b1);
    push(4'b1100, 1'b0);
    wait_presc(1);
    strobe(-2, 0, 1'b0);
    drain(5 * STEP_DIV);
    push(4'b1000, 1'b1);
    push(4'b0000, 1'b0);
    wait_presc(1);
    strobe(-2, 0, 1'b1);
    drain(5 * STEP_DIV);

    // Saturation: 3x(+255) then flipped -256 clamps acc_x at +511.
    do_reset();
    for (int i = 0; i < 511; i++) push({tb_gray(i + 1), 2'b00}, (i == 510) ? 1'b0 : 1'b1);
    wait_presc(1);
    strobe(255, 0, 1'b0);
    strobe(255, 0, 1'b0);
    strobe(255, 0, 1'b0);
    strobe(-256, 0, 1'b1);
    check("busy_sat", {31'd0, busy}, 32'd1);
    drain(520 * STEP_DIV);

    // dy=+1 in the tick cycle with acc_y=1: step now, acc_y stays 1, step again.
    do_reset();
    push(4'b0001, 1'b1);
    push(4'b0011, 1'b0);
    wait_presc(1);
    strobe(0, 1, 1'b0);
    wait_presc(7);
    strobe(0, 1, 1'b0);
    check("busy_tick_strobe", {31'd0, busy}, 32'd1);
    drain(4 * STEP_DIV);

`ifdef TRACKBALL_JOY_EN
    // joy_left for 64 cycles: two X steps in the -1 direction.
    do_reset();
    push(4'b1000, 1'b0);
    push(4'b1100, 1'b0);
    joy_left = 1'b1;
    repeat (64) @(negedge clk);
    joy_left = 1'b0;
    drain(4 * STEP_DIV);

    // Opposing pair held: no X steps.
    do_reset();
    joy_left = 1'b1;
    joy_right = 1'b1;
    repeat (64) @(negedge clk);
    joy_left = 1'b0;
    joy_right = 1'b0;
    drain(4 * STEP_DIV);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
